// File: rtl/io_bridge_split_wide_if.sv
// io_bridge_split_wide_if: CPU-side command/response and peripheral-side beat/response signal bundle.
interface io_bridge_split_wide_if #(
    parameter int SW       = 128,
    parameter int MW       = 64,
    parameter int CHANNELS = 2,
    parameter int TIDW     = 8
);
    logic                   s_cyc_i;
    logic                   s_we_i;
    logic [SW/8-1:0]        s_sel_i;
    logic [31:0]            s_adr_i;
    logic [SW-1:0]          s_dat_i;
    logic [TIDW-1:0]        s_tid_i;
    logic                   s_busy_o;
    logic                   s_ack_o;
    logic                   s_err_o;
    logic [SW-1:0]          s_dat_o;
    logic [TIDW-1:0]        s_tid_o;
    logic                   m_cyc_o;
    logic                   m_we_o;
    logic [MW/8-1:0]        m_sel_o;
    logic [31:0]            m_adr_o;
    logic [MW-1:0]          m_dat_o;
    logic [TIDW-1:0]        m_tid_o;
    logic [CHANNELS-1:0]    ch_ack_i;
    logic [CHANNELS-1:0]    ch_err_i;
    logic [CHANNELS*MW-1:0] ch_dat_i;
    modport slave (
        input  s_cyc_i, s_we_i, s_sel_i, s_adr_i, s_dat_i, s_tid_i,
        output s_busy_o, s_ack_o, s_err_o, s_dat_o, s_tid_o
    );
    modport master (
        output m_cyc_o, m_we_o, m_sel_o, m_adr_o, m_dat_o, m_tid_o,
        input  ch_ack_i, ch_err_i, ch_dat_i
    );
endinterface

// File: rtl/io_bridge_split_wide.sv
// io_bridge_split_wide: splits wide CPU I/O commands into one narrow master beat per active lane and reassembles the response.
module io_bridge_split_wide #(
    parameter int SW       = 128,
    parameter int MW       = 64,
    parameter int CHANNELS = 2,
    parameter int TIDW     = 8,
    parameter int TIMEOUT  = 255
) (
    input logic clk_i,
    input logic rst_i,
    io_bridge_split_wide_if.slave  s_if,
    io_bridge_split_wide_if.master m_if
);
    localparam int R  = SW / MW;
    localparam int LB = MW / 8;
    localparam int LW = R > 1 ? $clog2(R) : 1;
    localparam int SB = $clog2(SW / 8);
    localparam int MB = $clog2(MW / 8);
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam int HW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q;
    logic            we_q, gap_q, err_q, s_busy_q, s_ack_q, s_err_q, m_cyc_q, m_we_q;
    logic [SW/8-1:0] sel_q;
    logic [31:0]     adr_q, m_adr_q;
    logic [SW-1:0]   dat_q, rbuf_q, s_dat_q;
    logic [TIDW-1:0] tid_q, s_tid_q, m_tid_q;
    logic [LW-1:0]   lane_q;
    logic [CW-1:0]   cnt_q;
    logic [LB-1:0]   m_sel_q;
    logic [MW-1:0]   m_dat_q;

    logic [R-1:0]    act_d, act_in_d;
    logic [LW:0]     first_d, next_d;
    logic            hit_d, hit_err_d, to_d;
    logic [HW-1:0]   ch_d;
    logic [MW-1:0]   hit_dat_d;

    // Returns {found, index} of the lowest active lane at or above 'from'.
    function automatic logic [LW:0] pick(input logic [R-1:0] act, input int from);
        logic [LW:0] r;
        r = '0;
        for (int k = R - 1; k >= 0; k--)
            if (act[k] && k >= from) r = {1'b1, LW'(k)};
        return r;
    endfunction

    always_comb begin
        for (int k = 0; k < R; k++) begin
            act_d[k]    = |sel_q[k*LB +: LB];
            act_in_d[k] = |s_if.s_sel_i[k*LB +: LB];
        end
        first_d = pick(act_in_d, 0);
        next_d  = pick(act_d, int'(lane_q) + 1);
        hit_d   = 1'b0;
        ch_d    = '0;
        for (int c = CHANNELS - 1; c >= 0; c--)
            if (m_if.ch_ack_i[c] || m_if.ch_err_i[c]) begin
                hit_d = 1'b1;
                ch_d  = HW'(c);
            end
        hit_err_d = m_if.ch_err_i[ch_d];
        hit_dat_d = m_if.ch_dat_i[ch_d*MW +: MW];
        to_d      = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            gap_q    <= 1'b0;
            err_q    <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            tid_q    <= '0;
            lane_q   <= '0;
            cnt_q    <= '0;
            rbuf_q   <= '0;
            s_busy_q <= 1'b0;
            s_ack_q  <= 1'b0;
            s_err_q  <= 1'b0;
            s_dat_q  <= '0;
            s_tid_q  <= '0;
            m_cyc_q  <= 1'b0;
            m_we_q   <= 1'b0;
            m_sel_q  <= '0;
            m_adr_q  <= '1;
            m_dat_q  <= '0;
            m_tid_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    s_ack_q  <= 1'b0;
                    s_err_q  <= 1'b0;
                    s_dat_q  <= '0;
                    s_busy_q <= 1'b0;
                    // A strobe in the response-pulse cycle (still busy) is dropped.
                    if (s_if.s_cyc_i && !s_busy_q) begin
                        we_q     <= s_if.s_we_i;
                        sel_q    <= s_if.s_sel_i;
                        adr_q    <= s_if.s_adr_i;
                        dat_q    <= s_if.s_dat_i;
                        tid_q    <= s_if.s_tid_i;
                        lane_q   <= first_d[LW-1:0];
                        err_q    <= 1'b0;
                        gap_q    <= 1'b0;
                        rbuf_q   <= '0;
                        s_busy_q <= 1'b1;
                        state_q  <= first_d[LW] ? ISSUE : RESP;
                    end
                end
                ISSUE: begin
                    if (gap_q) gap_q <= 1'b0;
                    else begin
                        m_cyc_q <= 1'b1;
                        m_we_q  <= we_q;
                        m_sel_q <= sel_q[lane_q*LB +: LB];
                        m_adr_q <= {adr_q[31:SB], SB'(0)} | (32'(lane_q) << MB);
                        m_dat_q <= dat_q[lane_q*MW +: MW];
                        m_tid_q <= tid_q;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (hit_d || to_d) begin
                        m_cyc_q <= 1'b0;
                        m_we_q  <= 1'b0;
                        m_sel_q <= '0;
                        m_adr_q <= '1;
                        if (hit_d && !hit_err_d) begin
                            if (!we_q) rbuf_q[lane_q*MW +: MW] <= hit_dat_d;
                            if (next_d[LW]) begin
                                lane_q  <= next_d[LW-1:0];
                                gap_q   <= 1'b1;
                                state_q <= ISSUE;
                            end else state_q <= RESP;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= RESP;
                        end
                    end else cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                    s_ack_q <= 1'b1;
                    s_err_q <= err_q;
                    s_tid_q <= tid_q;
                    s_dat_q <= rbuf_q;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s_if.s_busy_o = s_busy_q;
    assign s_if.s_ack_o  = s_ack_q;
    assign s_if.s_err_o  = s_err_q;
    assign s_if.s_dat_o  = s_dat_q;
    assign s_if.s_tid_o  = s_tid_q;
    assign m_if.m_cyc_o  = m_cyc_q;
    assign m_if.m_we_o   = m_we_q;
    assign m_if.m_sel_o  = m_sel_q;
    assign m_if.m_adr_o  = m_adr_q;
    assign m_if.m_dat_o  = m_dat_q;
    assign m_if.m_tid_o  = m_tid_q;
endmodule
